// File: rtl/fcvt_issue_buf_pkg.sv
// Shared FPU constants: destination tag width and converter latency, kept beside the
// fadd_p2/fsub_p2 stage counts the converter is built from.
package fcvt_issue_buf_pkg;

  localparam int FPU_TAG_W      = 5;
  localparam int FADD_P2_STAGES = 2;
  localparam int FSUB_P2_STAGES = 2;
  localparam int FPU_CVT_LAT    = FADD_P2_STAGES;

  typedef logic [31:0] fp32_t;

  // Occupancy/credit counters must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fcvt_obuf_fifo.sv
// Circular result buffer with occupancy count; head entry is registered storage, no bypass.
module fcvt_obuf_fifo
  import fcvt_issue_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic                      wr,
  input  logic [W-1:0]              wdata,
  input  logic                      rd,
  output logic [W-1:0]              rdata,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          rd_ok;
  logic          wr_ok;

  assign rd_ok = rd & (count != '0);
  // A pop in the same edge frees the slot, so a full buffer may still accept a write.
  assign wr_ok = wr & ((count != FULL) | rd_ok);
  assign rdata = mem[head];

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) tail <= tail + 1'b1;
      if (rd_ok) head <= head + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[tail] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn || flush)
    wr |-> ((count != FULL) || rd));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn || flush)
    rd |-> (count != '0));

endmodule

// File: rtl/fcvt_issue_buf.sv
// Handshake wrapper around the non-stallable int-to-float converter: credit-throttled issue,
// valid/tag tracking alongside the converter pipe, and an in-order output buffer.
module fcvt_issue_buf
  import fcvt_issue_buf_pkg::*;
#(
  parameter int LAT   = FPU_CVT_LAT,
  parameter int DEPTH = 4,
  parameter int TAG_W = FPU_TAG_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic signed [31:0] cvt_x,
  input  fp32_t              cvt_y,
  output logic               out_valid,
  input  logic               out_ready,
  output fp32_t              out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

  logic [CW-1:0]       credits;
  logic [CW-1:0]       count;
  logic                issue;
  logic                pop;
  logic                cap;
  logic [LAT-1:0]      vld_p;
  logic [TAG_W-1:0]    tag_p [LAT];
  logic [32+TAG_W-1:0] head_entry;

  // Credits are registered, so out_ready never reaches in_ready combinationally.
  assign in_ready = (credits != '0) & rstn & ~flush;
  assign issue    = in_valid & in_ready;
  assign cvt_x    = issue ? in_data : '0;

  // p0..p(LAT-1): valid/tag tracking, one stage per converter stage
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= in_tag;
    for (int i = 1; i < LAT; i++) tag_p[i] <= tag_p[i-1];
  end

  assign cap = vld_p[LAT-1];

  // capture: converter result lands in the output buffer
  fcvt_obuf_fifo #(
    .DEPTH (DEPTH),
    .W     (32 + TAG_W)
  ) u_obuf (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .wr    (cap),
    .wdata ({cvt_y, tag_p[LAT-1]}),
    .rd    (pop),
    .rdata (head_entry),
    .count (count)
  );

  assign out_valid = (count != '0) & rstn;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? head_entry[32+TAG_W-1:TAG_W] : '0;
  assign out_tag   = out_valid ? head_entry[TAG_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      credits <= CRED_MAX;
    end else begin
      case ({issue, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: ;
      endcase
    end
  end

  a_credit_range: assert property (@(posedge clk) disable iff (!rstn)
    credits <= CRED_MAX);

endmodule

// File: tb/tb_fcvt_issue_buf.sv
// Directed bench for fcvt_issue_buf with a LAT-stage int-to-float converter stub.
module tb_fcvt_issue_buf;
  import fcvt_issue_buf_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn, flush, in_valid, in_ready, out_valid, out_ready;
  logic signed [31:0] in_data, cvt_x;
  logic [31:0]        cvt_y, out_data;
  logic [TAG_W-1:0]   in_tag, out_tag;

  int checks = 0;
  int errors = 0;
  int outst  = 0;

  fcvt_issue_buf #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .cvt_x(cvt_x), .cvt_y(cvt_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  // Round-to-nearest-even signed int32 -> binary32.
  function automatic logic [31:0] int2f(input logic signed [31:0] x);
    logic [31:0] mag, m, rem, half;
    logic [7:0]  e;
    int          p, sh;
    if (x == 0) return 32'h0;
    mag = x[31] ? (~x + 32'd1) : x;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    e = 8'(127 + p);
    if (p <= 23) begin
      m = mag << (23 - p);
    end else begin
      sh   = p - 23;
      m    = mag >> sh;
      rem  = mag & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 32'd1;
      if (m[24]) begin
        m = m >> 1;
        e = e + 8'd1;
      end
    end
    return {x[31], e, m[22:0]};
  endfunction

  logic [31:0] cvt_pipe [LAT];
  always @(posedge clk) begin
    cvt_pipe[0] <= int2f(cvt_x);
    for (int i = 1; i < LAT; i++) cvt_pipe[i] <= cvt_pipe[i-1];
  end
  assign cvt_y = cvt_pipe[LAT-1];

  // Ops issued but not yet popped may never exceed DEPTH.
  always @(negedge clk) begin
    if (!rstn || flush) begin
      outst = 0;
    end else begin
      if (in_valid && in_ready) begin
        checks++;
        if (outst + 1 - ((out_valid && out_ready) ? 1 : 0) > DEPTH) begin
          errors++;
          $display("FAIL credit_overrun outstanding %0d limit %0d", outst + 1, DEPTH);
        end
      end
      outst = outst + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'sd9; in_tag = 5'd7;
    cyc(); cyc(); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", out_data); end
    checks++; if (out_tag !== 5'd0) begin errors++; $display("FAIL rst_out_tag got %h want 0", out_tag); end
    checks++; if (cvt_x !== 32'sd0) begin errors++; $display("FAIL rst_cvt_x got %h want 0", cvt_x); end
    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_rel_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    int n;
    in_valid = 1'b1; in_data = 32'sd5; in_tag = 5'd3; out_ready = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b want 1", in_ready); end
    checks++; if (cvt_x !== 32'sd5) begin errors++; $display("FAIL single_cvt_x got %h want 5", cvt_x); end
    cyc();
    in_valid = 1'b0; in_data = 32'sd0; n = 1; #1;
    while (!out_valid && n < 10) begin cyc(); n++; #1; end
    checks++; if (n != LAT + 1) begin errors++; $display("FAIL single_latency got %0d want %0d", n, LAT + 1); end
    checks++; if (out_data !== 32'h40A00000) begin errors++; $display("FAIL single_data got %h want 40a00000", out_data); end
    checks++; if (out_tag !== 5'd3) begin errors++; $display("FAIL single_tag got %0d want 3", out_tag); end
    out_ready = 1'b1; cyc(); out_ready = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_credit got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic signed [31:0] bp_in [5];
    int k;
    bp_in = '{-32'sd1, -32'sd2, -32'sd3, -32'sd4, -32'sd5};
    out_ready = 1'b0; in_valid = 1'b1; k = 0;
    for (int c = 0; c < 8; c++) begin
      in_data = bp_in[k]; in_tag = 5'(10 + k); #1;
      if (in_ready) k++;
      cyc();
    end
    #1;
    checks++; if (k != 4) begin errors++; $display("FAIL bp_issues got %0d want 4", k); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall got %b want 0", in_ready); end
    checks++; if (out_data !== 32'hBF800000 || out_tag !== 5'd10) begin errors++; $display("FAIL bp_head0 got %h/%0d want bf800000/10", out_data, out_tag); end
    out_ready = 1'b1; cyc(); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_fifth_ready got %b want 1", in_ready); end
    checks++; if (out_data !== 32'hC0000000 || out_tag !== 5'd11) begin errors++; $display("FAIL bp_head1 got %h/%0d want c0000000/11", out_data, out_tag); end
    cyc(); in_valid = 1'b0; #1;
    checks++; if (out_data !== 32'hC0400000 || out_tag !== 5'd12) begin errors++; $display("FAIL bp_head2 got %h/%0d want c0400000/12", out_data, out_tag); end
    cyc(); #1;
    checks++; if (out_data !== 32'hC0800000 || out_tag !== 5'd13) begin errors++; $display("FAIL bp_head3 got %h/%0d want c0800000/13", out_data, out_tag); end
    cyc(); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hC0A00000 || out_tag !== 5'd14) begin errors++; $display("FAIL bp_head4 got %b/%h/%0d want 1/c0a00000/14", out_valid, out_data, out_tag); end
    cyc(); out_ready = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    logic signed [31:0] st_in  [16];
    logic [31:0]        st_exp [16];
    int k, rcv, first, last;
    st_in  = '{32'sh7FFFFFFF, 32'sh80000000, 32'sh00800001, 32'sd1, 32'sd2, 32'sd3, -32'sd2, 32'sd0,
               32'sh01000001, 32'sh01000003, 32'sd10, 32'sd100, -32'sd100, 32'sd256, 32'sh00FFFFFF, 32'sd7};
    st_exp = '{32'h4F000000, 32'hCF000000, 32'h4B000001, 32'h3F800000, 32'h40000000, 32'h40400000,
               32'hC0000000, 32'h00000000, 32'h4B800000, 32'h4B800002, 32'h41200000, 32'h42C80000,
               32'hC2C80000, 32'h43800000, 32'h4B7FFFFF, 32'h40E00000};
    out_ready = 1'b1; k = 0; rcv = 0; first = -1; last = -1;
    for (int c = 0; c < 30; c++) begin
      if (k < 16) begin
        in_valid = 1'b1; in_data = st_in[k]; in_tag = 5'(k);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k < 16) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready op %0d got %b want 1", k, in_ready); end
        k++;
      end
      if (out_valid && rcv < 16) begin
        checks++; if (out_data !== st_exp[rcv]) begin errors++; $display("FAIL stream_data %0d got %h want %h", rcv, out_data, st_exp[rcv]); end
        checks++; if (out_tag !== 5'(rcv)) begin errors++; $display("FAIL stream_tag %0d got %0d want %0d", rcv, out_tag, rcv); end
        if (first < 0) first = c;
        last = c;
        rcv++;
      end
      cyc();
    end
    checks++; if (rcv != 16) begin errors++; $display("FAIL stream_count got %0d want 16", rcv); end
    checks++; if (first != LAT + 1) begin errors++; $display("FAIL stream_fill got %0d want %0d", first, LAT + 1); end
    checks++; if (last - first != 15) begin errors++; $display("FAIL stream_rate got %0d want 15", last - first); end
  endtask

  task automatic test_pop_capture();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'(11 + i); in_tag = 5'(20 + i); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pc_fill_ready %0d got %b want 1", i, in_ready); end
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pc_no_credit got %b want 0", in_ready); end
    checks++; if (out_data !== 32'h41300000) begin errors++; $display("FAIL pc_head0 got %h want 41300000", out_data); end
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'sd15; in_tag = 5'd24; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pc_credit_back got %b want 1", in_ready); end
    cyc(); in_valid = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pc_credit_used got %b want 0", in_ready); end
    cyc(); out_ready = 1'b1; #1;
    checks++; if (out_data !== 32'h41400000) begin errors++; $display("FAIL pc_head1 got %h want 41400000", out_data); end
    cyc(); #1;
    checks++; if (out_data !== 32'h41500000 || out_tag !== 5'd22) begin errors++; $display("FAIL pc_head2 got %h/%0d want 41500000/22", out_data, out_tag); end
    cyc(); #1;
    checks++; if (out_data !== 32'h41600000 || out_tag !== 5'd23) begin errors++; $display("FAIL pc_head3 got %h/%0d want 41600000/23", out_data, out_tag); end
    cyc(); #1;
    checks++; if (out_data !== 32'h41700000 || out_tag !== 5'd24) begin errors++; $display("FAIL pc_head4 got %h/%0d want 41700000/24", out_data, out_tag); end
    cyc(); out_ready = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pc_drained got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'sd20; in_tag = 5'd1; #1; cyc();
    in_data = 32'sd21; in_tag = 5'd2; #1; cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    in_valid = 1'b1; in_data = 32'sd22; in_tag = 5'd3; #1; cyc();
    in_data = 32'sd23; in_tag = 5'd4; #1; cyc();
    flush = 1'b1; in_data = 32'sd24; in_tag = 5'd5; out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    checks++; if (cvt_x !== 32'sd0) begin errors++; $display("FAIL flush_cvt_x got %h want 0", cvt_x); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_cycle_valid got %b want 1", out_valid); end
    cyc(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", in_ready); end
    repeat (3) cyc();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_late_capture got %b want 0", out_valid); end
    in_valid = 1'b1; in_data = 32'sd1; in_tag = 5'd9; #1;
    cyc(); in_valid = 1'b0;
    repeat (2) cyc();
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h3F800000 || out_tag !== 5'd9) begin errors++; $display("FAIL flush_next_op got %b/%h/%0d want 1/3f800000/9", out_valid, out_data, out_tag); end
    out_ready = 1'b1; cyc(); out_ready = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_only_one got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'(30 + i); in_tag = 5'(i); #1; cyc();
    end
    rstn = 1'b0; in_data = 32'sd40; in_tag = 5'd6; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0) begin errors++; $display("FAIL mid_rst_out got %b/%h/%0d want 0/0/0", out_valid, out_data, out_tag); end
    checks++; if (cvt_x !== 32'sd0) begin errors++; $display("FAIL mid_rst_cvt_x got %h want 0", cvt_x); end
    cyc(); rstn = 1'b1; in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0) begin errors++; $display("FAIL mid_after_out got %b/%h/%0d want 0/0/0", out_valid, out_data, out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_after_ready got %b want 1", in_ready); end
    repeat (3) cyc();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_late_capture got %b want 0", out_valid); end
    in_valid = 1'b1; in_data = 32'sd3; in_tag = 5'd17; #1;
    cyc(); in_valid = 1'b0;
    repeat (2) cyc();
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h40400000 || out_tag !== 5'd17) begin errors++; $display("FAIL mid_resume got %b/%h/%0d want 1/40400000/17", out_valid, out_data, out_tag); end
    cyc(); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_resume_pop got %b want 0", out_valid); end
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 32'sd0; in_tag = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_pop_capture();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
